// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU control unit: opcodes, FSM states,
// ALU functions, datapath select codes and decoder instruction classes.
package cpu_ctrl_pkg;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_AND   = 6'b010000;
  localparam logic [5:0] OP_ANDI  = 6'b010001;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_SLL   = 6'b011000;
  localparam logic [5:0] OP_SLTI  = 6'b100110;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_BNE   = 6'b110101;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [2:0] S_IF     = 3'b000;
  localparam logic [2:0] S_ID     = 3'b001;
  localparam logic [2:0] S_EXE_LS = 3'b010;
  localparam logic [2:0] S_MEM    = 3'b011;
  localparam logic [2:0] S_WB_LD  = 3'b100;
  localparam logic [2:0] S_EXE_BR = 3'b101;
  localparam logic [2:0] S_EXE_AL = 3'b110;
  localparam logic [2:0] S_WB_AL  = 3'b111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b110;

  localparam logic [1:0] PC_NEXT = 2'b00;
  localparam logic [1:0] PC_BR   = 2'b01;
  localparam logic [1:0] PC_RS   = 2'b10;
  localparam logic [1:0] PC_JMP  = 2'b11;

  localparam logic [1:0] RD_R31 = 2'b00;
  localparam logic [1:0] RD_RT  = 2'b01;
  localparam logic [1:0] RD_RD  = 2'b10;

  localparam logic [2:0] CLS_ALU  = 3'd0;
  localparam logic [2:0] CLS_MEM  = 3'd1;
  localparam logic [2:0] CLS_BR   = 3'd2;
  localparam logic [2:0] CLS_JMP  = 3'd3;
  localparam logic [2:0] CLS_HALT = 3'd4;
  localparam logic [2:0] CLS_ILL  = 3'd5;

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational opcode decoder: ALU controls, destination-register class and
// instruction class for the sequencing FSM.
module ctrl_decoder
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW    = 6,
  parameter int ALUOPW = 3
) (
  input  logic [OPW-1:0]    op,
  output logic [ALUOPW-1:0] alu_op,
  output logic              alu_src_a,
  output logic              alu_src_b,
  output logic              ext_sel,
  output logic              rtype,
  output logic [2:0]        cls
);

  always_comb begin
    alu_op    = ALU_ADD;
    alu_src_a = 1'b0;
    alu_src_b = 1'b0;
    ext_sel   = 1'b0;
    rtype     = 1'b0;
    cls       = CLS_ILL;
    case (op)
      OP_ADD:   begin cls = CLS_ALU; rtype = 1'b1; end
      OP_SUB:   begin cls = CLS_ALU; rtype = 1'b1; alu_op = ALU_SUB; end
      OP_AND:   begin cls = CLS_ALU; rtype = 1'b1; alu_op = ALU_AND; end
      OP_SLL:   begin cls = CLS_ALU; rtype = 1'b1; alu_op = ALU_SLL; alu_src_a = 1'b1; end
      OP_ADDIU: begin cls = CLS_ALU; alu_src_b = 1'b1; ext_sel = 1'b1; end
      OP_ANDI:  begin cls = CLS_ALU; alu_src_b = 1'b1; alu_op = ALU_AND; end
      OP_ORI:   begin cls = CLS_ALU; alu_src_b = 1'b1; alu_op = ALU_OR; end
      OP_SLTI:  begin cls = CLS_ALU; alu_src_b = 1'b1; ext_sel = 1'b1; alu_op = ALU_SLT; end
      OP_SW, OP_LW:          cls = CLS_MEM;
      OP_BEQ, OP_BNE:        cls = CLS_BR;
      OP_J, OP_JR, OP_JAL:   cls = CLS_JMP;
      OP_HALT:               cls = CLS_HALT;
      default:               cls = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: sequences IF/ID/EXE/MEM/WB and drives every
// datapath enable and select. HALT parks in the ID encoding with halted set.
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW    = 6,
  parameter int ALUOPW = 3
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic [OPW-1:0]    opCode,
  input  logic              zero,
  output logic              PCWre,
  output logic              IRWre,
  output logic              InsMemRW,
  output logic              ExtSel,
  output logic              ALUSrcA,
  output logic              ALUSrcB,
  output logic [ALUOPW-1:0] ALUOp,
  output logic              mRD,
  output logic              mWR,
  output logic              DBDataSrc,
  output logic              RegWre,
  output logic              WrRegDSrc,
  output logic [1:0]        RegDst,
  output logic [1:0]        PCSrc,
  output logic [2:0]        state_o,
  output logic              halted,
  output logic              illegal
);

  logic [2:0] state_q, state_d;
  logic       halted_q, halted_d;

  logic [ALUOPW-1:0] dec_alu_op;
  logic              dec_src_a, dec_src_b, dec_ext, dec_rtype;
  logic [2:0]        dec_cls;

  ctrl_decoder #(.OPW(OPW), .ALUOPW(ALUOPW)) u_dec (
    .op        (opCode),
    .alu_op    (dec_alu_op),
    .alu_src_a (dec_src_a),
    .alu_src_b (dec_src_b),
    .ext_sel   (dec_ext),
    .rtype     (dec_rtype),
    .cls       (dec_cls)
  );

  always_comb begin
    state_d   = state_q;
    halted_d  = halted_q;
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    InsMemRW  = 1'b0;
    ExtSel    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    ALUOp     = ALU_ADD;
    mRD       = 1'b0;
    mWR       = 1'b0;
    DBDataSrc = 1'b0;
    RegWre    = 1'b0;
    WrRegDSrc = 1'b0;
    RegDst    = RD_R31;
    PCSrc     = PC_NEXT;
    illegal   = 1'b0;

    if (!halted_q) begin
      case (state_q)
        S_IF: begin
          InsMemRW = 1'b1;
          IRWre    = 1'b1;
          state_d  = S_ID;
        end
        S_ID: begin
          case (dec_cls)
            CLS_JMP: begin
              PCWre   = 1'b1;
              state_d = S_IF;
              if (opCode == OP_JR) PCSrc = PC_RS;
              else                 PCSrc = PC_JMP;
              if (opCode == OP_JAL) begin
                RegWre    = 1'b1;
                RegDst    = RD_R31;
                WrRegDSrc = 1'b0;
              end
            end
            CLS_BR:   state_d = S_EXE_BR;
            CLS_MEM:  state_d = S_EXE_LS;
            CLS_ALU:  state_d = S_EXE_AL;
            CLS_HALT: halted_d = 1'b1;
            default: begin
              // Unknown opcode retires as a NOP so the program keeps moving.
              illegal = 1'b1;
              PCWre   = 1'b1;
              state_d = S_IF;
            end
          endcase
        end
        S_EXE_AL: begin
          ALUOp   = dec_alu_op;
          ALUSrcA = dec_src_a;
          ALUSrcB = dec_src_b;
          ExtSel  = dec_ext;
          state_d = S_WB_AL;
        end
        S_WB_AL: begin
          RegWre    = 1'b1;
          WrRegDSrc = 1'b1;
          RegDst    = dec_rtype ? RD_RD : RD_RT;
          PCWre     = 1'b1;
          state_d   = S_IF;
        end
        S_EXE_BR: begin
          ALUOp   = ALU_SUB;
          PCWre   = 1'b1;
          if ((opCode == OP_BNE) ? !zero : zero) PCSrc = PC_BR;
          state_d = S_IF;
        end
        S_EXE_LS: begin
          ALUOp   = ALU_ADD;
          ALUSrcB = 1'b1;
          ExtSel  = 1'b1;
          state_d = S_MEM;
        end
        S_MEM: begin
          if (opCode == OP_SW) begin
            mWR     = 1'b1;
            PCWre   = 1'b1;
            state_d = S_IF;
          end else begin
            mRD     = 1'b1;
            state_d = S_WB_LD;
          end
        end
        S_WB_LD: begin
          mRD       = 1'b1;
          DBDataSrc = 1'b1;
          RegWre    = 1'b1;
          RegDst    = RD_RT;
          WrRegDSrc = 1'b1;
          PCWre     = 1'b1;
          state_d   = S_IF;
        end
        default: state_d = S_IF;
      endcase
    end

    // Reset abandons the current instruction: nothing may commit this cycle.
    if (Reset) begin
      state_d  = S_IF;
      halted_d = 1'b0;
      PCWre    = 1'b0;
      IRWre    = 1'b0;
      RegWre   = 1'b0;
      mWR      = 1'b0;
      mRD      = 1'b0;
      illegal  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q  <= S_IF;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  assign state_o = state_q;
  assign halted  = halted_q;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control unit for the single-issue CPU datapath instantiated by `main`.
- Sequences each instruction through IF/ID/EXE/MEM/WB states from the decoded opCode and the ALU zero flag.
- Drives every datapath write enable, mux select and ALU operation select.
- Sits between the instruction register and the datapath; owns the PC-update decision.

Parameters:
- OPW, 6, opcode width (instruction[31:26]).
- ALUOPW, 3, ALU operation select width.

Ports:
- clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- opCode  in  OPW  opcode from instruction register, stable from end of IF.
- zero  in  1  ALU result == 0, valid in EXE_BR.
- PCWre  out  1  PC write enable.
- IRWre  out  1  instruction register load.
- InsMemRW  out  1  1 = instruction memory read.
- ExtSel  out  1  1 = sign-extend, 0 = zero-extend.
- ALUSrcA  out  1  1 = shamt, 0 = rs.
- ALUSrcB  out  1  1 = ext immediate, 0 = rt.
- ALUOp  out  ALUOPW  ALU function.
- mRD  out  1  data memory read.
- mWR  out  1  data memory write.
- DBDataSrc  out  1  1 = memory data, 0 = ALU result.
- RegWre  out  1  register file write.
- WrRegDSrc  out  1  1 = DB data, 0 = PC+4 (JAL).
- RegDst  out  2  write register: 00 = $31, 01 = rt, 10 = rd.
- PCSrc  out  2  00 = PC+4, 01 = branch target, 10 = rs (JR), 11 = jump target.
- state_o  out  3  current state, for debug/visibility.
- halted  out  1  HALT reached.
- illegal  out  1  one-cycle pulse on unknown opcode.

Behaviour:
- Opcodes:
  - ALU class: ADD 000000, SUB 000001, ADDIU 000010, AND 010000, ANDI 010001, ORI 010010, SLL 011000, SLTI 100110.
  - Memory class: SW 110000, LW 110001.
  - Branch class: BEQ 110100, BNE 110101.
  - Jump class: J 111000, JR 111001, JAL 111010.
  - HALT 111111.
- State encoding: IF 000, ID 001, EXE_LS 010, MEM 011, WB_LD 100, EXE_BR 101, EXE_AL 110, WB_AL 111, HLT (one-hot flag: stays at ID encoding with halted=1).
- State register updates on posedge clk. Outputs are combinational from state + opCode (+ zero for PCSrc/PCWre in EXE_BR).
- Reset (sampled high at posedge):
  - Next state is IF, halted=0.
  - While Reset is high, PCWre, IRWre, RegWre, mWR and mRD are forced to 0.
  - Reset mid-instruction abandons the instruction with no partial write in the following cycle.
- IF: InsMemRW=1, IRWre=1. Next state ID.
- ID, by opCode:
  - J: PCSrc=11, PCWre=1. Next IF.
  - JR: PCSrc=10, PCWre=1. Next IF.
  - JAL: RegWre=1, RegDst=00, WrRegDSrc=0, PCSrc=11, PCWre=1. Next IF.
  - BEQ/BNE: next EXE_BR.
  - SW/LW: next EXE_LS.
  - ALU class: next EXE_AL.
  - HALT: next HLT.
  - Unknown opcode: illegal=1 for one cycle, PCWre=1, PCSrc=00 (executes as NOP). Next IF.
- EXE_AL: ALUOp, ALUSrcA (SLL only), ALUSrcB (immediate ops) and ExtSel (ADDIU, SLTI) come from the decoder. Next WB_AL.
- WB_AL:
  - RegWre=1, DBDataSrc=0, WrRegDSrc=1.
  - RegDst=10 for R-type (ADD, SUB, AND, SLL), 01 for immediate ops.
  - PCWre=1, PCSrc=00. Next IF.
- EXE_BR:
  - ALUOp=SUB, ALUSrcB=0, PCWre=1.
  - PCSrc=01 if (BEQ & zero) | (BNE & ~zero), else 00.
  - Next IF.
- EXE_LS: ALUOp=ADD, ALUSrcB=1, ExtSel=1. Next MEM.
- MEM:
  - SW: mWR=1, PCWre=1, PCSrc=00. Next IF.
  - LW: mRD=1. Next WB_LD.
- WB_LD: mRD=1, DBDataSrc=1, RegWre=1, RegDst=01, WrRegDSrc=1, PCWre=1. Next IF.
- HLT: all enables 0, halted=1. Leaves only on Reset.
- Defaults in any state not listed above: all enables 0, selects 0.
- Invariants:
  - PCWre is high exactly once per instruction, in its final state.
  - IRWre is high only in IF.
- Cycles per instruction: J/JR/JAL 2, BEQ/BNE 3, ALU/SW 4, LW 5.

Decomposition:
- Package cpu_ctrl_pkg holds: opcode localparams, state encodings, ALUOp codes (ADD 000, SUB 001, SLL 010, OR 011, AND 100, SLT 110), PCSrc and RegDst codes.
- Sub-module ctrl_decoder is combinational: opCode -> {ALUOp, ALUSrcA, ALUSrcB, ExtSel, RegDst class, instruction class}.
- multicycle_ctrl holds the state register and per-state enable gating.

Test Plan:
- Reset held 2 cycles, then ADD (000000) → states IF,ID,EXE_AL,WB_AL,IF. RegWre=1, RegDst=10 and PCWre=1 only in WB_AL. PCWre=0 during reset.
- LW (110001) → 5 cycles. mRD=1 in MEM and WB_LD. RegWre=1, DBDataSrc=1 only in WB_LD. SW (110000) → mWR=1 in MEM only, 4 cycles, RegWre never 1.
- BEQ with zero=1 → PCSrc=01, PCWre=1 in EXE_BR. BEQ with zero=0 → PCSrc=00. BNE mirrors BEQ. Each takes 3 cycles.
- JAL (111010) → in ID: RegWre=1, RegDst=00, WrRegDSrc=0, PCSrc=11, PCWre=1. Next state IF. JR → PCSrc=10, 2 cycles.
- Opcode 101010 → illegal pulse exactly 1 cycle, PCWre=1, PCSrc=00, back to IF. HALT → halted=1 and all enables 0 for 10+ cycles until Reset, then IF.
- Reset asserted during MEM of SW → mWR=0 that cycle, state IF next. No PCWre pulse.
